dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: the memory-side end of the datapath's dmem_addr/dmem_wdata/dmem_rdata port.
//  Accepts one load/store request at a time over a valid/ready handshake and stalls it LATENCY wait cycles.
//  Applies RV32 byte/half/word lane selection and load sign/zero extension, then returns the response over valid/ready.
//  Sits between the core's memory stage and a word-organised on-chip RAM array held inside this block.
// PARAMETERS
//  WIDTH    32  data width; only 32 is supported
//  DADDR    10  byte-address width; array depth = 2**(DADDR-2) words
//  LATENCY   0  wait cycles inserted before the response, 0..15
// PORTS
//  clk         in   1      clock; all state changes on the rising edge
//  reset       in   1      asynchronous, active-high reset
//  req_valid   in   1      request present
//  req_ready   out  1      request accepted when req_valid && req_ready at a rising edge
//  req_we      in   1      1 = store, 0 = load
//  req_funct3  in   3      000 b, 001 h, 010 w, 100 bu, 101 hu
//  req_addr    in   DADDR  byte address
//  req_wdata   in   WIDTH  store data, right-aligned (lane 0 holds the source bits)
//  rsp_valid   out  1      response present
//  rsp_ready   in   1      response consumed when rsp_valid && rsp_ready at a rising edge
//  rsp_rdata   out  WIDTH  extended load data; 0 for stores and errors
//  rsp_err     out  1      misaligned access or illegal funct3
// BEHAVIOUR
//  Interface (already decided): one clock, clk; reset is asynchronous and active-high.
//  - States: IDLE, WAIT, RESP. Reset forces IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//    req_ready = (state==IDLE) && !reset.
//  - IDLE -> on accept, capture we/funct3/addr/wdata and check legality.
//    LATENCY==0: go directly to RESP. Otherwise go to WAIT and load counter=LATENCY.
//  - WAIT: decrement counter each cycle; on the edge where counter==1, go to RESP.
//    rsp_valid therefore rises LATENCY+1 cycles after the accept edge.
//  - Commit edge = the edge entering RESP:
//    - Stores write the array and set rsp_rdata=0.
//    - Loads register the extended data into rsp_rdata.
//    - rsp_err is registered on the same edge.
//  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready. On handshake go to IDLE.
//    No request is accepted in the same cycle, so the minimum issue interval is LATENCY+2 cycles.
//  - Word index = addr[DADDR-1:2]; lane = addr[1:0].
//  - Stores:
//    - sb: write wdata[7:0] to byte lane addr[1:0].
//    - sh: write wdata[15:0] to half lane addr[1].
//    - sw: write the full word.
//    - Unselected bytes are unchanged.
//  - Loads:
//    - lb/lh sign-extend and lbu/lhu zero-extend the selected lane to 32 bits.
//    - lw returns the full word.
//  - Error cases:
//    - h/hu with addr[0]=1.
//    - w with addr[1:0]!=0.
//    - funct3 in {011,110,111}.
//    - we=1 with funct3 100 or 101.
//  - On error: no array write, rsp_rdata=0, rsp_err=1. The handshake completes normally.
//  - Reset mid-operation (WAIT/RESP): the transaction is dropped and an uncommitted store never writes.
//  - Array contents are not reset; a read before any write returns X.
//  - Request inputs are ignored outside IDLE and need not be held after acceptance.
// TESTING
//  1 LATENCY=0: sw 0xDEADBEEF @0x010; lw @0x010 -> rsp_valid 1 cycle after accept, rdata 0xDEADBEEF, err 0.
//  2 sb wdata 0x00000080 @0x013 -> lb @0x013 = 0xFFFFFF80; lbu = 0x00000080; lw @0x010 = 0x80ADBEEF.
//  3 sh 0x1234 @0x011 -> err=1, rdata 0; then lw @0x010 still returns 0x80ADBEEF.
//  4 LATENCY=3: accept at cycle 0 -> rsp_valid at cycle 4, req_ready low in cycles 1-4;
//    rsp_ready held low 5 cycles -> rdata/err constant, then IDLE the cycle after handshake.
//  5 sw 0x11111111 @0x020 with LATENCY=3; assert reset in WAIT -> rsp_valid 0, req_ready 1 after release;
//    lw @0x020 returns the prior value.
//  6 funct3=011 load, and funct3=100 with we=1 -> err=1, no array change (verify with lw readback).

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, LATENCY wait cycles, RV32 lane
// select and load extension against an internal word-organised RAM.
module dmem_responder #(
    parameter int WIDTH   = 32,
    parameter int DADDR   = 10,
    parameter int LATENCY = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [DADDR-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err
);

    localparam int DEPTH = 2 ** (DADDR - 2);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic             we;
        logic [2:0]       funct3;
        logic [DADDR-1:0] addr;
        logic [WIDTH-1:0] wdata;
    } req_t;

    state_t           state, state_nxt;
    logic [3:0]       cnt;
    req_t             req_q, op;
    logic             accept, commit, op_err, wr_en;
    logic [DADDR-3:0] widx;
    logic [1:0]       lane;
    logic [3:0]       be;
    logic [31:0]      wr_data, rd_word, ld_data;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [WIDTH-1:0] mem [DEPTH];

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);

    // With LATENCY==0 the commit edge is the accept edge, so take the live request.
    always_comb begin
        op = req_q;
        if (state == IDLE) begin
            op.we     = req_we;
            op.funct3 = req_funct3;
            op.addr   = req_addr;
            op.wdata  = req_wdata;
        end
    end

    assign widx = op.addr[DADDR-1:2];
    assign lane = op.addr[1:0];

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (LATENCY == 0) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: if (cnt == 4'd1) begin
                state_nxt = RESP;
                commit    = 1'b1;
            end
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        case (op.funct3)
            3'b000:  op_err = 1'b0;
            3'b001:  op_err = op.addr[0];
            3'b010:  op_err = |op.addr[1:0];
            3'b100:  op_err = op.we;
            3'b101:  op_err = op.we | op.addr[0];
            default: op_err = 1'b1;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick the target.
    always_comb begin
        case (op.funct3[1:0])
            2'b00: begin
                be      = 4'b0001 << lane;
                wr_data = {4{op.wdata[7:0]}};
            end
            2'b01: begin
                be      = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{op.wdata[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                wr_data = op.wdata;
            end
        endcase
    end

    assign rd_word = mem[widx];
    assign ld_byte = rd_word[{lane, 3'b000} +: 8];
    assign ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (op.funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = rd_word;
        endcase
    end

    assign wr_en = commit && op.we && !op_err && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_q     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt   <= 4'(LATENCY);
                req_q <= op;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                rsp_err   <= op_err;
                rsp_rdata <= (op_err || op.we) ? '0 : ld_data;
            end
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[widx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=0 and LATENCY=3 instances, directed table,
// reset/hold corner sequences, and random traffic against a byte-level memory model.
module tb_dmem_responder;

    localparam int LAT1 = 3;

    logic              clk = 1'b0;
    logic [1:0]        rst;
    logic [1:0]        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [1:0][2:0]   req_funct3;
    logic [1:0][9:0]   req_addr;
    logic [1:0][31:0]  req_wdata, rsp_rdata;

    int npass = 0;
    int ntot  = 0;

    logic [7:0] mb [2][1024];

    always #5 clk = ~clk;

    dmem_responder #(.WIDTH(32), .DADDR(10), .LATENCY(0)) u_lat0 (
        .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.WIDTH(32), .DADDR(10), .LATENCY(LAT1)) u_lat3 (
        .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    typedef struct {
        logic        we;
        logic [2:0]  fn;
        logic [9:0]  a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Little-endian byte memory: a request is `size` consecutive bytes starting at `a`.
    function automatic void model(input int d, input logic we, input logic [2:0] fn,
                                  input logic [9:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic err);
        int sz;
        logic [31:0] v;
        sz  = (fn[1:0] == 2'd0) ? 1 : (fn[1:0] == 2'd1) ? 2 : 4;
        err = (fn == 3'b011) || (fn[2] && fn[1]) || (we && fn[2]) || ((int'(a) % sz) != 0);
        rd  = 32'd0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < sz; i++) mb[d][int'(a) + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < sz; i++) v = v | (32'(mb[d][int'(a) + i]) << (8*i));
            if (!fn[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
            rd = v;
        end
    endfunction

    task automatic txn(input int d, input logic we, input logic [2:0] fn, input logic [9:0] a,
                       input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                       input int hold);
        int  lat;
        bit  seen;
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = fn;
        req_addr[d]  = a;    req_wdata[d] = wd;
        chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        // Scramble the request lines: they must not matter after acceptance.
        req_valid[d] = 1'b0; req_we[d] = ~we; req_funct3[d] = ~fn;
        req_addr[d]  = ~a;   req_wdata[d] = $urandom;
        lat  = 1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            chk("req_ready_busy", 32'(req_ready[d]), 32'd0);
            if (rsp_valid[d]) seen = 1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        if (!seen) chk("rsp_timeout", 32'd0, 32'd1);
        else chk("latency", 32'(lat), (d == 0) ? 32'd1 : 32'(LAT1 + 1));
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
            chk("hold_rdata", rsp_rdata[d], erd);
            chk("hold_err", 32'(rsp_err[d]), 32'(eerr));
            @(negedge clk);
        end
        chk("rdata", rsp_rdata[d], erd);
        chk("err", 32'(rsp_err[d]), 32'(eerr));
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk("idle_after_hs", {30'd0, rsp_valid[d], req_ready[d]}, 32'd1);
    endtask

    initial begin
        logic [31:0] erd;
        logic        eerr;
        logic        we;
        logic [2:0]  fn;
        logic [9:0]  a;
        logic [31:0] wd;

        tbl[0]  = '{1'b1, 3'b010, 10'h010, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 3'b010, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 3'b000, 10'h013, 32'h00000080, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 3'b000, 10'h013, 32'h0,        32'hFFFFFF80, 1'b0};
        tbl[4]  = '{1'b0, 3'b100, 10'h013, 32'h0,        32'h00000080, 1'b0};
        tbl[5]  = '{1'b0, 3'b010, 10'h010, 32'h0,        32'h80ADBEEF, 1'b0};
        tbl[6]  = '{1'b1, 3'b001, 10'h011, 32'h00001234, 32'h0,        1'b1};
        tbl[7]  = '{1'b0, 3'b010, 10'h010, 32'h0,        32'h80ADBEEF, 1'b0};
        tbl[8]  = '{1'b0, 3'b011, 10'h010, 32'h0,        32'h0,        1'b1};
        tbl[9]  = '{1'b1, 3'b100, 10'h010, 32'h55555555, 32'h0,        1'b1};
        tbl[10] = '{1'b0, 3'b010, 10'h010, 32'h0,        32'h80ADBEEF, 1'b0};
        tbl[11] = '{1'b1, 3'b001, 10'h012, 32'h00001234, 32'h0,        1'b0};
        tbl[12] = '{1'b1, 3'b001, 10'h010, 32'hFFFF8001, 32'h0,        1'b0};
        tbl[13] = '{1'b0, 3'b010, 10'h010, 32'h0,        32'h12348001, 1'b0};
        tbl[14] = '{1'b0, 3'b001, 10'h010, 32'h0,        32'hFFFF8001, 1'b0};
        tbl[15] = '{1'b0, 3'b101, 10'h010, 32'h0,        32'h00008001, 1'b0};
        tbl[16] = '{1'b0, 3'b010, 10'h012, 32'h0,        32'h0,        1'b1};
        tbl[17] = '{1'b1, 3'b111, 10'h010, 32'hFFFFFFFF, 32'h0,        1'b1};
        tbl[18] = '{1'b0, 3'b010, 10'h010, 32'h0,        32'h12348001, 1'b0};
        tbl[19] = '{1'b0, 3'b000, 10'h011, 32'h0,        32'hFFFFFF80, 1'b0};
        tbl[20] = '{1'b0, 3'b101, 10'h012, 32'h0,        32'h00001234, 1'b0};

        rst = 2'b11;
        req_valid = '0; req_we = '0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        rsp_ready = '0;

        // Reset state
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", 32'(req_ready[d]), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("rst_rdata", rsp_rdata[d], 32'd0);
            chk("rst_err", 32'(rsp_err[d]), 32'd0);
        end
        rst = 2'b00;
        @(negedge clk);
        chk("post_rst_ready0", 32'(req_ready[0]), 32'd1);
        chk("post_rst_ready1", 32'(req_ready[1]), 32'd1);

        // Directed table on the zero-latency instance
        for (int i = 0; i < 21; i++)
            txn(0, tbl[i].we, tbl[i].fn, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].err, i % 2);

        // LATENCY=3: response timing and 5-cycle backpressure hold
        txn(1, 1'b1, 3'b010, 10'h030, 32'hCAFEF00D, 32'h0, 1'b0, 0);
        txn(1, 1'b0, 3'b010, 10'h030, 32'h0, 32'hCAFEF00D, 1'b0, 5);
        txn(1, 1'b0, 3'b001, 10'h031, 32'h0, 32'h0, 1'b1, 5);

        // Reset during WAIT drops an uncommitted store
        txn(1, 1'b1, 3'b010, 10'h020, 32'h22222222, 32'h0, 1'b0, 0);
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = 3'b010;
        req_addr[1]  = 10'h020; req_wdata[1] = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        rst[1] = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(rsp_valid[1]), 32'd0);
        rst[1] = 1'b0;
        @(negedge clk);
        chk("after_rst_valid", 32'(rsp_valid[1]), 32'd0);
        chk("after_rst_ready", 32'(req_ready[1]), 32'd1);
        repeat (5) @(negedge clk);
        chk("after_rst_stable", 32'(rsp_valid[1]), 32'd0);
        txn(1, 1'b0, 3'b010, 10'h020, 32'h0, 32'h22222222, 1'b0, 0);

        // Random traffic against the byte model, region 0x100..0x13F preloaded
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++) begin
                a  = 10'(32'h100 + 4 * w);
                wd = $urandom;
                model(d, 1'b1, 3'b010, a, wd, erd, eerr);
                txn(d, 1'b1, 3'b010, a, wd, erd, eerr, 0);
            end
            for (int n = 0; n < 40; n++) begin
                we = 1'($urandom_range(0, 1));
                fn = 3'($urandom_range(0, 7));
                a  = 10'(32'h100 + $urandom_range(0, 63));
                wd = $urandom;
                model(d, we, fn, a, wd, erd, eerr);
                txn(d, we, fn, a, wd, erd, eerr, int'($urandom_range(0, 2)));
            end
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
